pc_sequencer: RTL
=================

# pc_sequencer

Fetch-stage next-PC controller for the five-stage MIPS pipeline. It owns the PC register and sequences the branch-target adder path, selecting each cycle among sequential PC+4, the branch target (ID-stage PC+4 plus shifted offset), J-type and JR targets. It holds a redirect that arrives during a pipeline stall until the stall releases. It sits between the hazard unit and IF-stage instruction memory.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded by reset.
- `EXC_VEC`, 32'h0000_4180, exception entry address (used only with `PC_SEQ_EXC_EN`).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  hazard-unit freeze of IF/ID; PC must hold while high.
- `br_req`  in  1  ID stage resolves a taken branch or jump this cycle.
- `br_sel`  in  2  target source: 00 branch adder, 01 J-index, 10 JR register, 11 reserved (treated as 00).
- `br_base`  in  32  PC+4 of the branch/jump in ID.
- `br_offset`  in  32  sign-extended immediate, already shifted left by 2.
- `j_index`  in  26  instr_index field of J/JAL.
- `jr_target`  in  32  forwarded rs value for JR/JALR.
- `exc_req`  in  1  exception entry request (present only with `PC_SEQ_EXC_EN`).
- `pc`  out  32  current fetch address.
- `pc_plus4`  out  32  pc + 4, combinational.
- `redirect_pending`  out  1  high while in PEND state.
- `pc_misalign`  out  1  combinational, high when pc[1:0] != 0.

## Operation
- Target computation (combinational): branch = br_base + br_offset, mod 2^32 with carry discarded; jump = {br_base[31:28], j_index, 2'b00}; JR = jr_target.
- States: RUN, PEND.
- RUN, stall=0: pc <= target if br_req, else pc+4.
- RUN, stall=1, br_req=1: pend_target <= target; go to PEND; pc holds.
- RUN, stall=1, br_req=0: pc holds.
- PEND, stall=1: pc holds. If br_req=1, pend_target is overwritten with the current target (the branch is still held in ID).
- PEND, stall=0: pc <= target if br_req=1, otherwise pend_target. Return to RUN.
- Live br_req has priority over pend_target.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Misaligned targets (e.g. a bad JR) are loaded as-is and flagged only on pc_misalign. Downstream exception logic handles them.
- Reset at any time, including in PEND: pc=RESET_PC, state RUN, pend_target=0, redirect_pending=0.

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, redirect_pending=0, pc_misalign=0.
- Redirect latency: br_req with stall=0 in cycle N gives pc=target in cycle N+1. The delay slot is the instruction fetched in cycle N.
- Stalled redirect: pc=target in the cycle after the first cycle in which stall=0.
- No combinational path from stall or br_req to pc. Targets are combinational into the PC register D input only.

## Configuration
- `PC_SEQ_EXC_EN` defined: the exc_req port exists.
  - exc_req=1 has top priority and overrides stall, br_req and PEND.
  - Effect next edge: pc <= EXC_VEC, state RUN, pend_target cleared.
- `PC_SEQ_EXC_EN` undefined: the port, the EXC_VEC logic and the priority term are absent. EXC_VEC is an unused parameter.

## Structure
- Shared package holds:
  - br_sel encodings (SEL_BR=2'b00, SEL_J=2'b01, SEL_JR=2'b10);
  - the state encoding (RUN, PEND);
  - the default RESET_PC and EXC_VEC constants.
- Sub-module `npc_target_sel`: purely combinational target computation and br_sel mux, including the branch adder. Top level keeps the PC register, pend_target and the FSM.

## Test plan
- Reset deasserts, stall=0, no br_req for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
- pc=0x3010, br_req=1, br_sel=00, br_base=0x3010, br_offset=0xFFFF_FFF0 -> next pc=0x3000; with br_offset=0x0000_0020 -> next pc=0x3030.
- stall=1 for 2 cycles while br_req=1, br_sel=01, br_base=0x3020, j_index=0x0000C40 -> pc holds, redirect_pending=1; on the first stall=0 edge pc=0x0000_3100, redirect_pending=0.
- pc=0xFFFF_FFFC, no br_req -> pc=0x0000_0000. br_sel=10 with jr_target=0x3002 -> pc=0x3002, pc_misalign=1.
- reset asserted mid-PEND (asynchronously, between edges) -> pc=0x3000 and redirect_pending=0 immediately; no stale redirect after release.
- With `PC_SEQ_EXC_EN`: exc_req=1 together with stall=1 and PEND -> next pc=0x4180, redirect_pending=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage next-PC controller: target-select
// encodings, FSM state encoding and default reset/exception addresses.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEL_BR   = 2'b00,
        SEL_J    = 2'b01,
        SEL_JR   = 2'b10,
        SEL_RSVD = 2'b11
    } br_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] jump_target(input logic [31:0] base,
                                                input logic [25:0] index);
        return {base[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_npc_target_sel.sv
// Purely combinational redirect-target computation: branch adder, J-index
// concatenation and JR pass-through, selected by br_sel.
module npc_target_sel
    import pc_sequencer_pkg::*;
(
    input  logic [1:0]  br_sel,
    input  logic [31:0] br_base,
    input  logic [31:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] target
);

    logic [31:0] branch_target;
    logic [31:0] j_target;

    // Carry out of the adder is intentionally dropped (mod 2^32).
    assign branch_target = br_base + br_offset;
    assign j_target      = jump_target(br_base, j_index);

    always_comb begin
        target = branch_target;
        case (br_sel)
            SEL_J:   target = j_target;
            SEL_JR:  target = jr_target;
            default: target = branch_target;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with a RUN/PEND FSM that holds a redirect taken
// during a stall. Optional exception entry is enabled by PC_SEQ_EXC_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_req,
    input  logic [1:0]  br_sel,
    input  logic [31:0] br_base,
    input  logic [31:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc_req,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        pc_misalign
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] target;
    logic [31:0] pc_inc;

`ifndef PC_SEQ_EXC_EN
    logic [31:0] exc_vec_unused;
    assign exc_vec_unused = EXC_VEC;
`endif

    npc_target_sel u_target_sel (
        .br_sel    (br_sel),
        .br_base   (br_base),
        .br_offset (br_offset),
        .j_index   (j_index),
        .jr_target (jr_target),
        .target    (target)
    );

    assign pc_inc = pc_q + PC_STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Live br_req always beats the held target; stall/br_req only reach pc via pc_d.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    pc_d = br_req ? target : pc_inc;
                end else if (br_req) begin
                    pend_target_d = target;
                    state_d       = PEND;
                end
            end
            PEND: begin
                if (stall) begin
                    if (br_req) begin
                        pend_target_d = target;
                    end
                end else begin
                    pc_d    = br_req ? target : pend_target_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
`ifdef PC_SEQ_EXC_EN
        if (exc_req) begin
            pc_d          = EXC_VEC;
            state_d       = RUN;
            pend_target_d = '0;
        end
`endif
    end

    always_comb begin
        pc               = pc_q;
        pc_plus4         = pc_inc;
        redirect_pending = (state_q == PEND);
        pc_misalign      = |pc_q[1:0];
    end

endmodule
